// File: rtl/pulse_width_pkg.sv
`timescale 1ns/1ps
// Shared defaults and the pulse classification type for the pulse width classifier.
package pulse_width_pkg;

  localparam int unsigned N_CH_DEF  = 4;
  localparam int unsigned CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_OK,
    CLS_SHORT,
    CLS_LONG
  } pulse_class_t;

endpackage

// File: rtl/pulse_width_channel.sv
`timescale 1ns/1ps
// One channel of the pulse width classifier: edge detection, saturating
// length counter with sticky overflow, and window classification on trail.
module pulse_width_channel
  import pulse_width_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ai,
  input  logic [CNT_W-1:0] eff_min,
  input  logic [CNT_W-1:0] cfg_max,
  output logic             lead,
  output logic             trail,
  output logic             pulse_ok,
  output logic             pulse_short,
  output logic             pulse_long,
  output logic [CNT_W-1:0] pulse_len
);

  localparam logic [CNT_W-1:0] LEN_MAX = '1;

  logic             a_r;
  logic             ovf;
  logic [CNT_W-1:0] len;
  logic             at_max;
  logic             is_short;
  logic             is_long;

  // Previous active level, run length (saturating) and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= 1'b0;
      len <= '0;
      ovf <= 1'b0;
    end else begin
      a_r <= ai;
      if (ai) begin
        if (!at_max) len <= len + CNT_W'(1);
        ovf <= ovf | at_max;
      end else begin
        len <= '0;
        ovf <= 1'b0;
      end
    end
  end

  // Edge detection and classification, zero latency from the current sample.
  always_comb begin
    at_max      = (len == LEN_MAX);
    lead        = ai & ~a_r;
    trail       = ~ai & a_r;
    is_short    = (len < eff_min);
    is_long     = ~is_short & (ovf | (len > cfg_max));
    pulse_short = trail & is_short;
    pulse_long  = trail & is_long;
    pulse_ok    = trail & ~is_short & ~is_long;
    pulse_len   = trail ? len : '0;
  end

endmodule

// File: rtl/pulse_width_classifier.sv
`timescale 1ns/1ps
// Multi-channel pulse edge detector, length meter and window classifier.
module pulse_width_classifier
  import pulse_width_pkg::*;
#(
  parameter int unsigned N_CH        = N_CH_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter bit          ACTIVE_HIGH = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       a,
  input  logic [CNT_W-1:0]      cfg_min,
  input  logic [CNT_W-1:0]      cfg_max,
  output logic [N_CH-1:0]       lead,
  output logic [N_CH-1:0]       trail,
  output logic [N_CH-1:0]       pulse_ok,
  output logic [N_CH-1:0]       pulse_short,
  output logic [N_CH-1:0]       pulse_long,
  output logic [N_CH*CNT_W-1:0] pulse_len
);

  logic [N_CH-1:0]  ai;
  logic [CNT_W-1:0] eff_min;

  // Normalise polarity so channels always see active-high pulses; a zero
  // minimum behaves as one since every pulse is at least one cycle long.
  always_comb begin
    ai      = ACTIVE_HIGH ? a : ~a;
    eff_min = (cfg_min == '0) ? CNT_W'(1) : cfg_min;
  end

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    pulse_width_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .ai         (ai[i]),
      .eff_min    (eff_min),
      .cfg_max    (cfg_max),
      .lead       (lead[i]),
      .trail      (trail[i]),
      .pulse_ok   (pulse_ok[i]),
      .pulse_short(pulse_short[i]),
      .pulse_long (pulse_long[i]),
      .pulse_len  (pulse_len[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_pulse_width_classifier.sv
`timescale 1ns/1ps
// Scoreboard bench: an active-high 4-channel instance and an active-low
// 1-channel instance, checked every cycle against a run-length model.
module tb_pulse_width_classifier;
  import pulse_width_pkg::*;

  localparam int unsigned NC = 4;
  localparam int unsigned CW = 4;
  localparam int          LM = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NC-1:0] a = '0;
  logic          an = 1'b1;
  logic [CW-1:0] cfg_min = 4'd1;
  logic [CW-1:0] cfg_max = 4'd1;

  logic [NC-1:0]    lead, trail, p_ok, p_sh, p_lg;
  logic [NC*CW-1:0] p_len;
  logic             n_lead, n_trail, n_ok, n_sh, n_lg;
  logic [CW-1:0]    n_len;

  pulse_width_classifier #(.N_CH(NC), .CNT_W(CW), .ACTIVE_HIGH(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .cfg_min(cfg_min), .cfg_max(cfg_max),
    .lead(lead), .trail(trail), .pulse_ok(p_ok), .pulse_short(p_sh),
    .pulse_long(p_lg), .pulse_len(p_len)
  );

  pulse_width_classifier #(.N_CH(1), .CNT_W(CW), .ACTIVE_HIGH(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .a(an), .cfg_min(cfg_min), .cfg_max(cfg_max),
    .lead(n_lead), .trail(n_trail), .pulse_ok(n_ok), .pulse_short(n_sh),
    .pulse_long(n_lg), .pulse_len(n_len)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          lead;
    logic          trail;
    pulse_class_t  cls;
    logic [CW-1:0] len;
  } ch_exp_t;

  typedef struct packed {
    ch_exp_t [NC-1:0] m;
    ch_exp_t          n;
  } sb_t;

  sb_t sbq[$];
  int  run[NC];
  int  run_n;
  int  total = 0;
  int  bad = 0;

  logic [NC-1:0] obs_lead, obs_ok;
  logic          obs_n_lead, obs_n_ok;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs of one channel given the active sample and the number
  // of consecutive active samples already seen (unbounded).
  function automatic ch_exp_t model_ch(input logic ai, input int r,
                                       input logic [CW-1:0] mn, input logic [CW-1:0] mx);
    ch_exp_t e;
    int lenv;
    int effmin;
    e.lead  = ai && (r == 0);
    e.trail = !ai && (r > 0);
    e.cls   = CLS_NONE;
    e.len   = '0;
    if (e.trail) begin
      lenv   = (r > LM) ? LM : r;
      effmin = (mn == 0) ? 1 : int'(mn);
      e.len  = CW'(lenv);
      if (lenv < effmin)                 e.cls = CLS_SHORT;
      else if (r > LM || lenv > int'(mx)) e.cls = CLS_LONG;
      else                               e.cls = CLS_OK;
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(NC); i++) run[i] = 0;
    run_n = 0;
  endtask

  // Starts and ends at posedge+1: drive, predict, compare at negedge.
  task automatic do_cycle(input logic [NC-1:0] av, input logic anv);
    sb_t e;
    sb_t g;
    logic [NC-1:0]    el, et, eo, es, eg;
    logic [NC*CW-1:0] elen;
    a  = av;
    an = anv;
    for (int i = 0; i < int'(NC); i++) e.m[i] = model_ch(av[i], run[i], cfg_min, cfg_max);
    e.n = model_ch(~anv, run_n, cfg_min, cfg_max);
    sbq.push_back(e);
    @(negedge clk);
    if (sbq.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      g = sbq.pop_front();
      for (int i = 0; i < int'(NC); i++) begin
        el[i] = g.m[i].lead;
        et[i] = g.m[i].trail;
        eo[i] = (g.m[i].cls == CLS_OK);
        es[i] = (g.m[i].cls == CLS_SHORT);
        eg[i] = (g.m[i].cls == CLS_LONG);
        elen[i*CW +: CW] = g.m[i].len;
      end
      check_eq("lead", lead, el);
      check_eq("trail", trail, et);
      check_eq("pulse_ok", p_ok, eo);
      check_eq("pulse_short", p_sh, es);
      check_eq("pulse_long", p_lg, eg);
      check_eq("pulse_len", p_len, elen);
      check_eq("n_outputs", {n_lead, n_trail, n_ok, n_sh, n_lg, n_len},
               {g.n.lead, g.n.trail, g.n.cls == CLS_OK, g.n.cls == CLS_SHORT,
                g.n.cls == CLS_LONG, g.n.len});
    end
    obs_lead   = lead;
    obs_ok     = p_ok;
    obs_n_lead = n_lead;
    obs_n_ok   = n_ok;
    for (int i = 0; i < int'(NC); i++) run[i] = av[i] ? run[i] + 1 : 0;
    run_n = anv ? 0 : run_n + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse0(input int n);
    for (int k = 0; k < n; k++) do_cycle(4'b0001, 1'b1);
    do_cycle(4'b0000, 1'b1);
  endtask

  initial begin
    logic [15:0] leg_a;
    logic [15:0] leg_lead;
    logic [15:0] leg_ok;
    logic [6:0]  pol_a;
    logic [6:0]  pol_lead;
    logic [6:0]  pol_ok;
    logic [NC-1:0] rv;
    logic          rn;

    model_reset();
    leg_a    = 16'b1001011011110001;
    pol_a    = 7'b1101111;
    leg_lead = '0;
    leg_ok   = '0;
    pol_lead = '0;
    pol_ok   = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_flags", {lead, trail, p_ok, p_sh, p_lg}, 20'd0);
    check_eq("reset_len", p_len, 16'd0);
    check_eq("reset_n", {n_lead, n_trail, n_ok, n_sh, n_lg, n_len}, 9'd0);
    rst_n = 1'b1;

    // Legacy equivalence on channel 0, polarity test on the active-low instance
    cfg_min = 4'd1; cfg_max = 4'd1;
    for (int i = 0; i < 16; i++) begin
      do_cycle({3'b000, leg_a[15-i]}, (i < 7) ? pol_a[6-i] : 1'b1);
      leg_lead[15-i] = obs_lead[0];
      leg_ok[15-i]   = obs_ok[0];
      if (i < 7) begin
        pol_lead[6-i] = obs_n_lead;
        pol_ok[6-i]   = obs_n_ok;
      end
    end
    check_eq("legacy_lead", leg_lead, 16'b1001010010000001);
    check_eq("legacy_ok", leg_ok, 16'b0100100000000000);
    check_eq("polarity_lead", pol_lead, 7'b0010000);
    check_eq("polarity_ok", pol_ok, 7'b0001000);

    // Window 2..3 with pulses of length 1..4
    cfg_min = 4'd2; cfg_max = 4'd3;
    for (int n = 1; n <= 4; n++) pulse0(n);

    // Saturation at LEN_MAX
    cfg_min = 4'd1; cfg_max = 4'd15;
    pulse0(15);
    pulse0(16);
    pulse0(40);

    // Staggered overlapping pulses, cfg_min=0 acts as 1
    cfg_min = 4'd0; cfg_max = 4'd3;
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < int'(NC); i++) rv[i] = (t >= i) && (t < 2 * i + 1);
      do_cycle(rv, 1'b1);
    end

    // Inverted window: nothing can be ok
    cfg_min = 4'd3; cfg_max = 4'd2;
    pulse0(2);
    pulse0(3);

    // cfg changed mid-pulse: value at trail applies
    cfg_min = 4'd1; cfg_max = 4'd1;
    do_cycle(4'b0001, 1'b1);
    do_cycle(4'b0001, 1'b1);
    cfg_min = 4'd2; cfg_max = 4'd4;
    do_cycle(4'b0001, 1'b1);
    do_cycle(4'b0000, 1'b1);

    // Reset asserted between edges during the 3rd active cycle
    cfg_min = 4'd1; cfg_max = 4'd15;
    do_cycle(4'b0001, 1'b1);
    do_cycle(4'b0001, 1'b1);
    a = 4'b0001;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_mid_trail", trail, 4'd0);
    check_eq("rst_mid_class", {p_ok, p_sh, p_lg}, 12'd0);
    check_eq("rst_mid_len", p_len, 16'd0);
    @(negedge clk);
    check_eq("rst_hold_trail", {trail, p_ok, p_sh, p_lg}, 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_cycle(4'b0001, 1'b1);
    check_eq("rst_release_lead", obs_lead, 4'b0001);
    do_cycle(4'b0001, 1'b1);
    do_cycle(4'b0000, 1'b1);

    // Random traffic with occasional cfg changes
    rv = '0;
    rn = 1'b1;
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        cfg_min = CW'($urandom_range(0, 15));
        cfg_max = CW'($urandom_range(0, 15));
      end
      for (int i = 0; i < int'(NC); i++)
        if ($urandom_range(0, 4) == 0) rv[i] = ~rv[i];
      if ($urandom_range(0, 3) == 0) rn = ~rn;
      do_cycle(rv, rn);
    end
    do_cycle('0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
